// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the parallel-to-serial word shifter: FSM encoding
// and default geometry.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_GAP   = 1;

    // Gap counter is sized for the largest legal GAP (15).
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/bit_serializer.sv
// Serializes WIDTH-bit words onto a single bit stream, one bit per clock,
// with an optional idle gap after each word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = DEFAULT_GAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_CNT_W-1:0] gap_cnt;
    logic               last_bit;
    logic               transfer;

    // Handshake and output decode; none of this depends on din, so an
    // unknown data word can never disturb the control path.
    always_comb begin
        last_bit   = (state == S_SHIFT) && (bit_cnt == LAST_BIT);
        din_ready  = (state == S_IDLE) || (last_bit && (GAP == 0));
        transfer   = din_valid && din_ready;
        sout_valid = (state == S_SHIFT);
        word_done  = last_bit;
        busy       = (state != S_IDLE);
        if (MSB_FIRST != 0) begin
            sout = sout_valid & shift_reg[WIDTH-1];
        end else begin
            sout = sout_valid & shift_reg[0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (transfer) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_bit) begin
                    if (GAP > 0) begin
                        state_next = S_GAP;
                    end else if (transfer) begin
                        state_next = S_SHIFT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Reset clears the word in flight as well, so an aborted word leaves no
    // residue that could reappear on sout.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            if (transfer) begin
                shift_reg <= din;
                bit_cnt   <= '0;
            end else if (state == S_SHIFT) begin
                if (MSB_FIRST != 0) begin
                    shift_reg <= shift_reg << 1;
                end else begin
                    shift_reg <= shift_reg >> 1;
                end
                bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
            end
            if (state == S_GAP) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule
